// File: rtl/pcie_us_cq_route_ctrl.sv
// Routing controller for the UltraScale CQ demux: BAR-to-port table, per-port
// non-posted throttling and dropped-packet statistics.
module pcie_us_cq_route_ctrl #(
   parameter int M_COUNT    = 2,
   parameter int FUNC_COUNT = 1,
   parameter int NP_LIMIT   = 8,
   parameter int CL_M_COUNT = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cq_tvalid,
   input  logic                    cq_tready,
   input  logic                    cq_tlast,
   input  logic [3:0]              req_type,
   input  logic [7:0]              target_function,
   input  logic [2:0]              bar_id,
   output logic                    enable,
   output logic                    drop,
   output logic [M_COUNT-1:0]      select,
   input  logic                    cfg_wr_en,
   input  logic [2:0]              cfg_wr_bar,
   input  logic [CL_M_COUNT-1:0]   cfg_wr_port,
   input  logic                    cfg_wr_valid,
   input  logic [M_COUNT-1:0]      np_done,
   output logic [M_COUNT*8-1:0]    np_outstanding,
   output logic [31:0]             stat_drop_count,
   output logic                    busy
);

   localparam logic [8:0]  FUNC_LIM = 9'(FUNC_COUNT);
   localparam logic [7:0]  NP_MAX   = 8'(NP_LIMIT);
   localparam logic [31:0] PORT_LIM = 32'(M_COUNT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUTE = 2'd1,
      FRAME = 2'd2
   } state_t;

   state_t                  state_reg;
   logic [CL_M_COUNT-1:0]   port_reg;
   logic                    drop_reg;
   logic                    np_reg;

   logic [7:0]              tbl_valid_reg;
   logic [CL_M_COUNT-1:0]   tbl_port_reg [8];

   logic                    is_posted;
   logic                    is_np;
   logic                    new_drop;
   logic                    beat;
   logic                    first_beat;
   logic                    stall;
   logic [M_COUNT-1:0]      stall_vec;

   always_comb begin
      is_posted = (req_type == 4'b0001) || (req_type == 4'b0011);
      is_np     = (req_type == 4'b0000) || (req_type == 4'b0010);
      new_drop  = !(is_posted || is_np) || !tbl_valid_reg[bar_id] ||
                  ({1'b0, target_function} >= FUNC_LIM);
   end

   assign beat       = cq_tvalid && cq_tready;
   assign stall      = |stall_vec;
   assign enable     = (state_reg == FRAME) || ((state_reg == ROUTE) && !stall);
   // Gating with the stall keeps the count bounded even if tready is not qualified by enable.
   assign first_beat = (state_reg == ROUTE) && beat && !stall;
   assign drop       = (state_reg != IDLE) && drop_reg;
   assign busy       = (state_reg != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            tbl_valid_reg[i] <= 1'b0;
            tbl_port_reg[i]  <= '0;
         end
      end else if (cfg_wr_en) begin
         tbl_valid_reg[cfg_wr_bar] <= cfg_wr_valid && (32'(cfg_wr_port) < PORT_LIM);
         tbl_port_reg[cfg_wr_bar]  <= cfg_wr_port;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         port_reg  <= '0;
         drop_reg  <= 1'b0;
         np_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cq_tvalid) begin
                  port_reg  <= tbl_port_reg[bar_id];
                  drop_reg  <= new_drop;
                  np_reg    <= is_np;
                  state_reg <= ROUTE;
               end
            end
            ROUTE: begin
               if (first_beat) begin
                  state_reg <= cq_tlast ? IDLE : FRAME;
               end
            end
            FRAME: begin
               if (beat && cq_tlast) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < M_COUNT; gi++) begin : g_port
         logic [7:0] cnt_reg;
         logic       hit;
         logic       inc;
         logic       dec;

         assign hit            = (port_reg == CL_M_COUNT'(gi));
         assign inc            = first_beat && np_reg && !drop_reg && hit;
         assign dec            = np_done[gi] && (cnt_reg != 8'd0);
         assign stall_vec[gi]  = np_reg && !drop_reg && hit && (cnt_reg == NP_MAX);
         assign select[gi]     = (state_reg != IDLE) && !drop_reg && hit;
         assign np_outstanding[gi*8 +: 8] = cnt_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= 8'd0;
            end else if (inc && !dec) begin
               cnt_reg <= cnt_reg + 8'd1;
            end else if (dec && !inc) begin
               cnt_reg <= cnt_reg - 8'd1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_drop_count <= 32'd0;
      end else if (first_beat && drop_reg && (stat_drop_count != 32'hFFFF_FFFF)) begin
         stat_drop_count <= stat_drop_count + 32'd1;
      end
   end

endmodule
